dcache_controller: RTL and testbench

Direct-mapped, write-back, write-allocate L1 data cache controller between the CPU's MEM stage and the off-chip data memory. It replaces the single-cycle data memory port: hits complete in the requesting cycle; misses assert `cpu_stall_o` until the line is refilled, with the victim written back first if dirty. The pipeline freezes all stage registers while stall is high.

---
 rtl/dcache_pkg.sv | 28 ++
 rtl/dcache_sram.sv | 57 +++++
 rtl/dcache_controller.sv | 118 +++++++++++
 tb/tb_dcache_controller.sv | 259 +++++++++++++++++++++++++
 4 files changed

// File: rtl/dcache_pkg.sv
// Shared types and sizing helpers for the L1 data cache controller.
package dcache_pkg;

  localparam int unsigned ADDR_W     = 32;
  localparam int unsigned WORD_W     = 32;
  localparam int unsigned LINE_BITS  = 256;
  localparam int unsigned WORD_SEL_W = 3;
  localparam int unsigned OFFSET_W   = 5;

  typedef enum logic [1:0] {IDLE, WRITEBACK, ALLOCATE, REFILL} state_t;

  // Memory-side request payload
  typedef struct packed {
    logic                 enable;
    logic                 write;
    logic [ADDR_W-1:0]    addr;
    logic [LINE_BITS-1:0] data;
  } mem_req_t;

  function automatic int unsigned index_w(input int unsigned lines);
    return $clog2(lines);
  endfunction

  function automatic int unsigned tag_w(input int unsigned lines);
    return ADDR_W - OFFSET_W - $clog2(lines);
  endfunction

endpackage

// File: rtl/dcache_sram.sv
// Tag/valid/dirty/data storage: combinational read by index, synchronous
// full-line refill or single-word merge.
module dcache_sram
  import dcache_pkg::*;
#(
  parameter int unsigned LINES = 16,
  parameter int unsigned IDX_W = 4,
  parameter int unsigned TAG_W = 23
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic [IDX_W-1:0]      index,
  output logic                  rd_valid,
  output logic                  rd_dirty,
  output logic [TAG_W-1:0]      rd_tag,
  output logic [LINE_BITS-1:0]  rd_data,
  input  logic                  fill_en,
  input  logic [TAG_W-1:0]      fill_tag,
  input  logic [LINE_BITS-1:0]  fill_data,
  input  logic                  merge_en,
  input  logic [WORD_SEL_W-1:0] merge_sel,
  input  logic [WORD_W-1:0]     merge_word
);

  logic [LINES-1:0]     valid_q;
  logic [LINES-1:0]     dirty_q;
  logic [TAG_W-1:0]     tag_q  [LINES];
  logic [LINE_BITS-1:0] data_q [LINES];

  assign rd_valid = valid_q[index];
  assign rd_dirty = dirty_q[index];
  assign rd_tag   = tag_q[index];
  assign rd_data  = data_q[index];

  // Only the state bits are cleared; stale tags/data are masked by valid
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      valid_q <= '0;
      dirty_q <= '0;
    end else if (fill_en) begin
      valid_q[index] <= 1'b1;
      dirty_q[index] <= 1'b0;
    end else if (merge_en) begin
      dirty_q[index] <= 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (fill_en) begin
      tag_q[index]  <= fill_tag;
      data_q[index] <= fill_data;
    end else if (merge_en) begin
      data_q[index][{merge_sel, 5'b0} +: WORD_W] <= merge_word;
    end
  end

endmodule

// File: rtl/dcache_controller.sv
// Direct-mapped write-back/write-allocate L1 D-cache: hit logic, miss FSM
// and memory-side muxing around dcache_sram.
module dcache_controller #(
  parameter int unsigned LINES     = 16,
  parameter int unsigned LINE_BITS = 256
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic [31:0]          cpu_addr_i,
  input  logic                 cpu_MemRead_i,
  input  logic                 cpu_MemWrite_i,
  input  logic [31:0]          cpu_data_i,
  output logic [31:0]          cpu_data_o,
  output logic                 cpu_stall_o,
  output logic [31:0]          mem_addr_o,
  output logic                 mem_enable_o,
  output logic                 mem_write_o,
  output logic [LINE_BITS-1:0] mem_data_o,
  input  logic [LINE_BITS-1:0] mem_data_i,
  input  logic                 mem_ack_i
);

  import dcache_pkg::*;

  localparam int unsigned IDX_W = index_w(LINES);
  localparam int unsigned TAG_W = tag_w(LINES);

  state_t state_q, state_d;
  mem_req_t mem_req;

  logic [IDX_W-1:0]      req_index;
  logic [TAG_W-1:0]      req_tag;
  logic [WORD_SEL_W-1:0] req_word;
  logic                  req_active;
  logic                  hit;
  logic                  rd_valid, rd_dirty;
  logic [TAG_W-1:0]      rd_tag;
  logic [LINE_BITS-1:0]  rd_data;
  logic                  fill_en, merge_en;
  logic                  unused_byte_bits;

  assign req_index        = cpu_addr_i[OFFSET_W +: IDX_W];
  assign req_tag          = cpu_addr_i[ADDR_W-1 -: TAG_W];
  assign req_word         = cpu_addr_i[OFFSET_W-1:2];
  assign unused_byte_bits = ^cpu_addr_i[1:0];
  assign req_active       = cpu_MemRead_i | cpu_MemWrite_i;
  assign hit              = rd_valid && (rd_tag == req_tag);

  dcache_sram #(
    .LINES(LINES),
    .IDX_W(IDX_W),
    .TAG_W(TAG_W)
  ) u_sram (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .index     (req_index),
    .rd_valid  (rd_valid),
    .rd_dirty  (rd_dirty),
    .rd_tag    (rd_tag),
    .rd_data   (rd_data),
    .fill_en   (fill_en),
    .fill_tag  (req_tag),
    .fill_data (mem_data_i),
    .merge_en  (merge_en),
    .merge_sel (req_word),
    .merge_word(cpu_data_i)
  );

  always_ff @(posedge clk_i) begin
    if (rst_i) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // Next state, stall, lookup result and memory request
  always_comb begin
    state_d     = state_q;
    mem_req     = '0;
    cpu_stall_o = 1'b1;
    cpu_data_o  = '0;
    fill_en     = 1'b0;
    merge_en    = 1'b0;
    unique case (state_q)
      IDLE: begin
        cpu_stall_o = req_active && !hit;
        if (req_active && hit) begin
          // A simultaneous read+write resolves as a store
          if (cpu_MemWrite_i) merge_en = 1'b1;
          else                cpu_data_o = rd_data[{req_word, 5'b0} +: WORD_W];
        end else if (req_active) begin
          state_d = (rd_valid && rd_dirty) ? WRITEBACK : ALLOCATE;
        end
      end
      WRITEBACK: begin
        mem_req.enable = 1'b1;
        mem_req.write  = 1'b1;
        mem_req.addr   = {rd_tag, req_index, OFFSET_W'(0)};
        mem_req.data   = rd_data;
        if (mem_ack_i) state_d = ALLOCATE;
      end
      ALLOCATE: begin
        mem_req.enable = 1'b1;
        mem_req.addr   = {req_tag, req_index, OFFSET_W'(0)};
        if (mem_ack_i) begin
          fill_en = 1'b1;
          state_d = REFILL;
        end
      end
      REFILL: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign mem_enable_o = mem_req.enable;
  assign mem_write_o  = mem_req.write;
  assign mem_addr_o   = mem_req.addr;
  assign mem_data_o   = mem_req.data;

endmodule

// File: tb/tb_dcache_controller.sv
// Directed scoreboard bench for dcache_controller with a fixed-latency memory model.
module tb_dcache_controller;

  localparam int L = 10;

  typedef struct packed {
    logic         write;
    logic [31:0]  addr;
    logic [255:0] data;
  } txn_t;

  logic         clk = 1'b0;
  logic         rst;
  logic [31:0]  cpu_addr;
  logic         cpu_rd, cpu_wr;
  logic [31:0]  cpu_wdata;
  logic [31:0]  cpu_rdata;
  logic         cpu_stall;
  logic [31:0]  mem_addr;
  logic         mem_enable, mem_write;
  logic [255:0] mem_wdata;
  logic [255:0] mem_rdata;
  logic         mem_ack;

  int n_cmp = 0;
  int n_bad = 0;

  txn_t        obs_q[$];
  txn_t        exp_q[$];
  logic [31:0] exp_rd_q[$];
  logic [255:0] mem_store [logic [31:0]];

  int   cnt;
  logic gap;

  always #5 clk = ~clk;

  dcache_controller dut (
    .clk_i         (clk),
    .rst_i         (rst),
    .cpu_addr_i    (cpu_addr),
    .cpu_MemRead_i (cpu_rd),
    .cpu_MemWrite_i(cpu_wr),
    .cpu_data_i    (cpu_wdata),
    .cpu_data_o    (cpu_rdata),
    .cpu_stall_o   (cpu_stall),
    .mem_addr_o    (mem_addr),
    .mem_enable_o  (mem_enable),
    .mem_write_o   (mem_write),
    .mem_data_o    (mem_wdata),
    .mem_data_i    (mem_rdata),
    .mem_ack_i     (mem_ack)
  );

  function automatic logic [31:0] word_pat(input logic [31:0] a);
    return {a[15:0] ^ 16'h5A5A, a[15:0]};
  endfunction

  function automatic logic [255:0] line_pat(input logic [31:0] base);
    logic [255:0] l;
    for (int i = 0; i < 8; i++) l[i*32 +: 32] = word_pat(base + 32'(i * 4));
    return l;
  endfunction

  // Memory: ack visible in the L-th request cycle, one idle turnaround cycle after each ack
  always @(posedge clk) begin
    if (rst) begin
      mem_ack <= 1'b0;
      cnt     <= 0;
      gap     <= 1'b0;
    end else if (mem_ack) begin
      mem_ack <= 1'b0;
      gap     <= 1'b1;
      cnt     <= 0;
    end else if (gap) begin
      gap <= 1'b0;
    end else if (mem_enable) begin
      if (cnt == L - 2) begin
        mem_ack <= 1'b1;
        cnt     <= 0;
        obs_q.push_back({mem_write, mem_addr, mem_wdata});
        if (mem_write) mem_store[mem_addr] = mem_wdata;
        else mem_rdata <= mem_store.exists(mem_addr) ? mem_store[mem_addr] : line_pat(mem_addr);
      end else begin
        cnt <= cnt + 1;
      end
    end else begin
      cnt <= 0;
    end
  end

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic access(input logic [31:0] a, input logic rd, input logic wr, input logic [31:0] wd,
                        output int cycles, output logic [31:0] rdata, output logic saw_en);
    @(negedge clk);
    cpu_addr = a; cpu_rd = rd; cpu_wr = wr; cpu_wdata = wd;
    #1;
    cycles = 0;
    saw_en = 1'b0;
    while (cpu_stall && cycles < 200) begin
      saw_en = saw_en | mem_enable;
      cycles++;
      @(negedge clk);
      #1;
    end
    saw_en = saw_en | mem_enable;
    rdata  = cpu_rdata;
    @(posedge clk);
    #1;
    cpu_rd = 1'b0; cpu_wr = 1'b0;
  endtask

  task automatic check_txns(input string tag);
    txn_t e, o;
    chk({tag, "_count"}, 256'(obs_q.size()), 256'(exp_q.size()));
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front();
      o = obs_q.pop_front();
      chk({tag, "_write"}, 256'(o.write), 256'(e.write));
      chk({tag, "_addr"}, 256'(o.addr), 256'(e.addr));
      chk({tag, "_data"}, o.data, e.data);
    end
    exp_q.delete();
    obs_q.delete();
  endtask

  task automatic check_read(input string tag, input logic [31:0] rdata);
    logic [31:0] e;
    e = exp_rd_q.pop_front();
    chk(tag, 256'(rdata), 256'(e));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int cyc;
    logic [31:0] rdata;
    logic saw_en;
    logic [255:0] vline;
    int wait_cyc;

    rst = 1'b1; cpu_addr = '0; cpu_rd = 1'b0; cpu_wr = 1'b0; cpu_wdata = '0;
    mem_rdata = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_stall", 256'(cpu_stall), 256'(0));
    chk("rst_mem_enable", 256'(mem_enable), 256'(0));
    chk("rst_mem_write", 256'(mem_write), 256'(0));
    chk("rst_mem_addr", 256'(mem_addr), 256'(0));
    chk("rst_mem_data", mem_wdata, 256'(0));
    chk("rst_cpu_data", 256'(cpu_rdata), 256'(0));
    rst = 1'b0;

    // Cold read: clean miss, L+2 stall cycles
    exp_rd_q.push_back(word_pat(32'h40));
    exp_q.push_back({1'b0, 32'h40, 256'(0)});
    access(32'h40, 1'b1, 1'b0, '0, cyc, rdata, saw_en);
    chk("cold_stall", 256'(cyc), 256'(L + 2));
    check_read("cold_data", rdata);
    check_txns("cold_txn");

    // Read hit
    exp_rd_q.push_back(word_pat(32'h44));
    access(32'h44, 1'b1, 1'b0, '0, cyc, rdata, saw_en);
    chk("hit_stall", 256'(cyc), 256'(0));
    chk("hit_no_mem", 256'(saw_en), 256'(0));
    check_read("hit_data", rdata);

    // Write hit, then dirty eviction from an aliasing read
    access(32'h44, 1'b0, 1'b1, 32'hDEADBEEF, cyc, rdata, saw_en);
    chk("wr_hit_stall", 256'(cyc), 256'(0));
    vline = line_pat(32'h40);
    vline[32 +: 32] = 32'hDEADBEEF;
    exp_q.push_back({1'b1, 32'h40, vline});
    exp_q.push_back({1'b0, 32'h240, 256'(0)});
    exp_rd_q.push_back(word_pat(32'h240));
    access(32'h240, 1'b1, 1'b0, '0, cyc, rdata, saw_en);
    chk("evict_stall", 256'(cyc), 256'(2 * L + 3));
    check_read("evict_data", rdata);
    check_txns("evict_txn");

    // Write miss allocates, merges and dirties the line
    exp_q.push_back({1'b0, 32'h80, 256'(0)});
    access(32'h80, 1'b0, 1'b1, 32'h12345678, cyc, rdata, saw_en);
    chk("wmiss_stall", 256'(cyc), 256'(L + 2));
    check_txns("wmiss_txn");
    exp_rd_q.push_back(32'h12345678);
    access(32'h80, 1'b1, 1'b0, '0, cyc, rdata, saw_en);
    chk("wmiss_reread_stall", 256'(cyc), 256'(0));
    check_read("wmiss_reread_data", rdata);
    vline = line_pat(32'h80);
    vline[31:0] = 32'h12345678;
    exp_q.push_back({1'b1, 32'h80, vline});
    exp_q.push_back({1'b0, 32'h280, 256'(0)});
    exp_rd_q.push_back(word_pat(32'h280));
    access(32'h280, 1'b1, 1'b0, '0, cyc, rdata, saw_en);
    chk("wmiss_evict_stall", 256'(cyc), 256'(2 * L + 3));
    check_read("wmiss_evict_data", rdata);
    check_txns("wmiss_evict_txn");

    // Reset while a refill is outstanding
    @(negedge clk);
    cpu_addr = 32'h100; cpu_rd = 1'b1;
    wait_cyc = 0;
    while (!mem_enable && wait_cyc < 20) begin
      @(negedge clk);
      wait_cyc++;
    end
    repeat (3) @(negedge clk);
    chk("mid_enable", 256'(mem_enable), 256'(1));
    chk("mid_write", 256'(mem_write), 256'(0));
    chk("mid_addr", 256'(mem_addr), 256'(32'h100));
    rst = 1'b1; cpu_rd = 1'b0;
    @(posedge clk);
    #1;
    chk("rstmid_enable", 256'(mem_enable), 256'(0));
    chk("rstmid_stall", 256'(cpu_stall), 256'(0));
    @(negedge clk);
    rst = 1'b0;
    check_txns("rstmid_txn");
    exp_q.push_back({1'b0, 32'h100, 256'(0)});
    exp_rd_q.push_back(word_pat(32'h100));
    access(32'h100, 1'b1, 1'b0, '0, cyc, rdata, saw_en);
    chk("rstmid_remiss_stall", 256'(cyc), 256'(L + 2));
    check_read("rstmid_remiss_data", rdata);
    check_txns("rstmid_remiss_txn");

    // Read and write both set on a hit behaves as a store
    access(32'h104, 1'b1, 1'b1, 32'hCAFEF00D, cyc, rdata, saw_en);
    chk("both_stall", 256'(cyc), 256'(0));
    exp_rd_q.push_back(32'hCAFEF00D);
    access(32'h104, 1'b1, 1'b0, '0, cyc, rdata, saw_en);
    check_read("both_reread_data", rdata);
    vline = line_pat(32'h100);
    vline[32 +: 32] = 32'hCAFEF00D;
    exp_q.push_back({1'b1, 32'h100, vline});
    exp_q.push_back({1'b0, 32'h300, 256'(0)});
    exp_rd_q.push_back(word_pat(32'h300));
    access(32'h300, 1'b1, 1'b0, '0, cyc, rdata, saw_en);
    chk("both_evict_stall", 256'(cyc), 256'(2 * L + 3));
    check_read("both_evict_data", rdata);
    check_txns("both_evict_txn");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
